sha256_round_unit: RTL and testbench

SHA256_ROUND_UNIT -- requirements
Module: sha256_round_unit

---
 rtl/sha256_round_unit_pkg.sv | 31 +++
 rtl/sha256_round_comb.sv | 41 ++++
 rtl/sha256_round_unit.sv | 180 ++++++++++++++++++
 tb/tb_sha256_round_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_round_unit_pkg.sv
// Shared types, word width and SHA-256 round helper functions for sha256_round_unit.
package sha256_round_unit_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic word_t bsig0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t bsig1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// One purely combinational SHA-256 compression round (a..h, W, K -> a'..h').
module sha256_round_comb
  import sha256_round_unit_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  input  word_t i_c,
  input  word_t i_d,
  input  word_t i_e,
  input  word_t i_f,
  input  word_t i_g,
  input  word_t i_h,
  input  word_t i_w,
  input  word_t i_k,
  output word_t o_a,
  output word_t o_b,
  output word_t o_c,
  output word_t o_d,
  output word_t o_e,
  output word_t o_f,
  output word_t o_g,
  output word_t o_h
);

  word_t w_t1;
  word_t w_t2;

  // Sums wrap at 2^32; carries out of bit 31 are simply dropped.
  assign w_t1 = i_h + bsig1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;
  assign w_t2 = bsig0(i_a) + maj(i_a, i_b, i_c);

  assign o_a = w_t1 + w_t2;
  assign o_b = i_a;
  assign o_c = i_b;
  assign o_d = i_c;
  assign o_e = i_d + w_t1;
  assign o_f = i_e;
  assign o_g = i_f;
  assign o_h = i_g;

endmodule

// File: rtl/sha256_round_unit.sv
// Iterative SHA-256 round engine: ROUNDS rounds after a programmable start delay.
// Define SHA256_ROUND_OUTREG_EN to add one output register stage (done/out one cycle later).
module sha256_round_unit
  import sha256_round_unit_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  delay0,
  input  logic [31:0] state_in0,
  input  logic [31:0] state_in1,
  input  logic [31:0] state_in2,
  input  logic [31:0] state_in3,
  input  logic [31:0] state_in4,
  input  logic [31:0] state_in5,
  input  logic [31:0] state_in6,
  input  logic [31:0] state_in7,
  input  logic [31:0] in_w,
  input  logic [31:0] in_k,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic [31:0] out3,
  output logic [31:0] out4,
  output logic [31:0] out5,
  output logic [31:0] out6,
  output logic [31:0] out7,
  output logic        done,
  output logic        busy
);

  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);
`ifdef SHA256_ROUND_OUTREG_EN
  localparam logic OUTREG = 1'b1;
`else
  localparam logic OUTREG = 1'b0;
`endif

  state_e     r_state;
  state_e     w_next;
  logic [7:0] r_dly;
  logic [6:0] r_rnd;
  word_t      r_wv  [8];
  word_t      w_nx  [8];
  word_t      r_out [8];
  logic       r_done;
  logic       r_busy;

  sha256_round_comb u_round (
    .i_a (r_wv[0]), .i_b (r_wv[1]), .i_c (r_wv[2]), .i_d (r_wv[3]),
    .i_e (r_wv[4]), .i_f (r_wv[5]), .i_g (r_wv[6]), .i_h (r_wv[7]),
    .i_w (in_w),    .i_k (in_k),
    .o_a (w_nx[0]), .o_b (w_nx[1]), .o_c (w_nx[2]), .o_d (w_nx[3]),
    .o_e (w_nx[4]), .o_f (w_nx[5]), .o_g (w_nx[6]), .o_h (w_nx[7])
  );

  // Next-state logic; a run in any state restarts the operation.
  always_comb begin
    w_next = r_state;
    if (run) begin
      if (delay0 == 8'd0) begin
        w_next = ST_ROUND;
      end else begin
        w_next = ST_DELAY;
      end
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_IDLE;
        ST_DELAY: begin
          if (r_dly == 8'd0) begin
            w_next = ST_ROUND;
          end else begin
            w_next = ST_DELAY;
          end
        end
        ST_ROUND: begin
          if (r_rnd == LAST_RND) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_ROUND;
          end
        end
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // State, counters, working variables and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dly   <= 8'd0;
      r_rnd   <= 7'd0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_wv[i]  <= '0;
        r_out[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == ST_DONE);
      r_busy  <= (w_next == ST_DELAY) || (w_next == ST_ROUND) ||
                 (OUTREG && (w_next == ST_DONE));
      if (run) begin
        // DELAY spends delay0 cycles: it leaves once the counter has reached zero.
        r_dly   <= (delay0 == 8'd0) ? 8'd0 : (delay0 - 8'd1);
        r_rnd   <= 7'd0;
        r_wv[0] <= state_in0;
        r_wv[1] <= state_in1;
        r_wv[2] <= state_in2;
        r_wv[3] <= state_in3;
        r_wv[4] <= state_in4;
        r_wv[5] <= state_in5;
        r_wv[6] <= state_in6;
        r_wv[7] <= state_in7;
      end else if (r_state == ST_DELAY) begin
        if (r_dly != 8'd0) begin
          r_dly <= r_dly - 8'd1;
        end
      end else if (r_state == ST_ROUND) begin
        r_rnd <= r_rnd + 7'd1;
        for (int i = 0; i < 8; i++) begin
          r_wv[i] <= w_nx[i];
        end
        if (r_rnd == LAST_RND) begin
          for (int i = 0; i < 8; i++) begin
            r_out[i] <= w_nx[i];
          end
        end
      end
    end
  end

`ifdef SHA256_ROUND_OUTREG_EN
  word_t r_out_q [8];
  logic  r_done_q;

  // Extra output stage delaying result and done by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_out_q[i] <= '0;
      end
    end else begin
      r_done_q <= r_done;
      for (int i = 0; i < 8; i++) begin
        r_out_q[i] <= r_out[i];
      end
    end
  end

  assign out0 = r_out_q[0];
  assign out1 = r_out_q[1];
  assign out2 = r_out_q[2];
  assign out3 = r_out_q[3];
  assign out4 = r_out_q[4];
  assign out5 = r_out_q[5];
  assign out6 = r_out_q[6];
  assign out7 = r_out_q[7];
  assign done = r_done_q;
`else
  assign out0 = r_out[0];
  assign out1 = r_out[1];
  assign out2 = r_out[2];
  assign out3 = r_out[3];
  assign out4 = r_out[4];
  assign out5 = r_out[5];
  assign out6 = r_out[6];
  assign out7 = r_out[7];
  assign done = r_done;
`endif

  assign busy = r_busy;

endmodule

// File: tb/tb_sha256_round_unit.sv
// Scoreboard bench for sha256_round_unit: a ROUNDS=1 and a ROUNDS=16 instance,
// expected results come from an independent SHA-256 round model.
module tb_sha256_round_unit;

  typedef logic [7:0][31:0] st_t;
  typedef struct {
    st_t val;
    int  cyc;
    int  busy;
  } exp_t;

`ifdef SHA256_ROUND_OUTREG_EN
  localparam int OUTLAT = 1;
`else
  localparam int OUTLAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        run1;
  logic        run16;
  logic [7:0]  delay0;
  st_t         st_in;
  logic [31:0] in_w;
  logic [31:0] in_k;
  st_t         o1;
  st_t         o16;
  logic        done1, busy1, done16, busy16;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   bc1     = 0;
  int   bc16    = 0;
  st_t  last1   = '0;
  st_t  last16  = '0;
  exp_t q1[$];
  exp_t q16[$];
  exp_t mon_e;
  logic [31:0] cur_w [64];
  logic [31:0] cur_k [64];
  st_t  h0;
  st_t  s_tmp;

  always #5 clk = ~clk;

  sha256_round_unit #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .reset(reset), .run(run1), .delay0(delay0),
    .state_in0(st_in[0]), .state_in1(st_in[1]), .state_in2(st_in[2]), .state_in3(st_in[3]),
    .state_in4(st_in[4]), .state_in5(st_in[5]), .state_in6(st_in[6]), .state_in7(st_in[7]),
    .in_w(in_w), .in_k(in_k),
    .out0(o1[0]), .out1(o1[1]), .out2(o1[2]), .out3(o1[3]),
    .out4(o1[4]), .out5(o1[5]), .out6(o1[6]), .out7(o1[7]),
    .done(done1), .busy(busy1)
  );

  sha256_round_unit #(.ROUNDS(16)) u_dut16 (
    .clk(clk), .reset(reset), .run(run16), .delay0(delay0),
    .state_in0(st_in[0]), .state_in1(st_in[1]), .state_in2(st_in[2]), .state_in3(st_in[3]),
    .state_in4(st_in[4]), .state_in5(st_in[5]), .state_in6(st_in[6]), .state_in7(st_in[7]),
    .in_w(in_w), .in_k(in_k),
    .out0(o16[0]), .out1(o16[1]), .out2(o16[2]), .out3(o16[3]),
    .out4(o16[4]), .out5(o16[5]), .out6(o16[6]), .out7(o16[7]),
    .done(done16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic st_t sha_round(input st_t s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, chv, mj, t1, t2;
    st_t r;
    {h, g, f, e, d, c, b, a} = s;
    s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    chv = (e & f) ^ ((~e) & g);
    t1  = h + s1 + chv + k + w;
    s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    mj  = (a & b) ^ (a & c) ^ (b & c);
    t2  = s0 + mj;
    r = {g, f, e, d + t1, c, b, a, t1 + t2};
    return r;
  endfunction

  function automatic st_t run_model(input st_t s, input int nr);
    st_t r = s;
    for (int t = 0; t < nr; t++) r = sha_round(r, cur_w[t], cur_k[t]);
    return r;
  endfunction

  // Drives one operation starting at the current negedge; abort_k>0 cuts it short
  // before edge abort_k (by a new run from the caller, or by reset when use_rst).
  task automatic run_op(input int sel, input int d, input int nr, input st_t s,
                        input int abort_k, input bit use_rst,
                        input bit use_const, input st_t cval);
    exp_t e;
    int t;
    e.val  = use_const ? cval : run_model(s, nr);
    e.cyc  = cyc + 1 + d + nr + OUTLAT;
    e.busy = d + nr + OUTLAT;
    if (sel == 1) q1.push_back(e); else q16.push_back(e);
    delay0 = d[7:0];
    st_in  = s;
    in_w   = $urandom;
    in_k   = $urandom;
    if (sel == 1) run1 = 1'b1; else run16 = 1'b1;
    for (int k = 1; k <= d + nr; k++) begin
      @(negedge clk);
      run1   = 1'b0;
      run16  = 1'b0;
      delay0 = 8'($urandom);
      st_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (k == abort_k) begin
        if (sel == 1) void'(q1.pop_back()); else void'(q16.pop_back());
        if (use_rst) begin
          reset = 1'b1;
          @(posedge clk); #1;
          for (int i = 0; i < 8; i++) check($sformatf("rst_out%0d", i), o16[i], 32'd0);
          check("rst_done", {31'd0, done16}, 32'd0);
          check("rst_busy", {31'd0, busy16}, 32'd0);
          @(negedge clk);
          reset = 1'b0;
        end
        return;
      end
      t = k - d - 1;
      if (t >= 0) begin
        in_w = cur_w[t];
        in_k = cur_k[t];
      end else begin
        in_w = $urandom;
        in_k = $urandom;
      end
    end
    @(negedge clk);
    in_w = $urandom;
    in_k = $urandom;
  endtask

  // Monitor: cycle count, busy length, scoreboard pop on done, output hold while busy.
  always begin
    @(posedge clk); #1;
    cyc++;
    if (reset) begin
      bc1 = 0; bc16 = 0; last1 = '0; last16 = '0;
    end else begin
      if (run1)  bc1  = 0;
      if (run16) bc16 = 0;
      if (busy1)  bc1++;
      if (busy16) bc16++;
    end
    if (done1) begin
      if (q1.size() == 0) check("d1_unexp_done", 32'd1, 32'd0);
      else begin
        mon_e = q1.pop_front();
        for (int i = 0; i < 8; i++) check($sformatf("d1_out%0d", i), o1[i], mon_e.val[i]);
        check("d1_done_cyc", cyc, mon_e.cyc);
        check("d1_busy_len", bc1, mon_e.busy);
      end
      last1 = o1;
    end else if (busy1) begin
      for (int i = 0; i < 8; i++) check($sformatf("d1_hold%0d", i), o1[i], last1[i]);
    end
    if (done16) begin
      if (q16.size() == 0) check("d16_unexp_done", 32'd1, 32'd0);
      else begin
        mon_e = q16.pop_front();
        for (int i = 0; i < 8; i++) check($sformatf("d16_out%0d", i), o16[i], mon_e.val[i]);
        check("d16_done_cyc", cyc, mon_e.cyc);
        check("d16_busy_len", bc16, mon_e.busy);
      end
      last16 = o16;
    end else if (busy16) begin
      for (int i = 0; i < 8; i++) check($sformatf("d16_hold%0d", i), o16[i], last16[i]);
    end
  end

  task automatic load_abc();
    logic [31:0] kt [16];
    kt = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
           32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
           32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
           32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174};
    for (int t = 0; t < 16; t++) begin
      cur_k[t] = kt[t];
      cur_w[t] = 32'd0;
    end
    cur_w[0]  = 32'h61626380;
    cur_w[15] = 32'h00000018;
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    st_t req32;
    reset = 1'b1; run1 = 1'b0; run16 = 1'b0; delay0 = 8'd0;
    st_in = '0; in_w = 32'd0; in_k = 32'd0;
    h0    = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
             32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    req32 = {32'h1f83d9ab, 32'h9b05688c, 32'h510e527f, 32'hfa2a4622,
             32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667, 32'h5d6aebcd};
    for (int t = 0; t < 64; t++) begin cur_w[t] = 32'd0; cur_k[t] = 32'd0; end
    load_abc();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("init_out%0d", i), o16[i], 32'd0);
    check("init_d1_out0", o1[0], 32'd0);
    check("init_done", {30'd0, done1, done16}, 32'd0);
    check("init_busy", {30'd0, busy1, busy16}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1, 0, 1, h0, -1, 1'b0, 1'b1, req32);           gap();  // single abc round
    run_op(16, 0, 16, h0, -1, 1'b0, 1'b0, '0);            gap();  // 16 rounds, no delay
    run_op(16, 17, 16, h0, -1, 1'b0, 1'b0, '0);           gap();  // 16 rounds, delay 17
    run_op(16, 0, 16, h0, 5, 1'b1, 1'b0, '0);             gap();  // reset mid-run
    run_op(16, 0, 16, h0, -1, 1'b0, 1'b0, '0);            gap();

    // Restart at edge 8 with fresh stimulus.
    run_op(16, 0, 16, h0, 8, 1'b0, 1'b0, '0);
    for (int t = 0; t < 16; t++) begin cur_w[t] = $urandom; cur_k[t] = $urandom; end
    s_tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_op(16, 2, 16, s_tmp, -1, 1'b0, 1'b0, '0);         gap();

    // Modulo-2^32 wrap: everything all ones.
    cur_w[0] = 32'hffffffff;
    cur_k[0] = 32'hffffffff;
    run_op(1, 0, 1, '1, -1, 1'b0, 1'b0, '0);              gap();

    // Delay boundaries 255 and 1 with random data.
    s_tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_op(1, 255, 1, s_tmp, -1, 1'b0, 1'b0, '0);         gap();
    run_op(16, 1, 16, s_tmp, -1, 1'b0, 1'b0, '0);         gap();

    // run together with reset is ignored.
    reset = 1'b1;
    run16 = 1'b1;
    run1  = 1'b1;
    @(posedge clk); #1;
    check("rst_run_busy16", {31'd0, busy16}, 32'd0);
    check("rst_run_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    reset = 1'b0; run16 = 1'b0; run1 = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy16", {31'd0, busy16}, 32'd0);

    for (int i = 0; i < 400 && (q1.size() != 0 || q16.size() != 0); i++) @(negedge clk);
    check("drain_q1", q1.size(), 32'd0);
    check("drain_q16", q16.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
